// File: rtl/sync_fifo_pkg.sv
// Shared types and constants for the synchronous FIFO and its storage.
// Provides the FWFT output-stage state enum, level-width helper and default thresholds.
// No logic here; imported by the interface, storage and top-level FIFO.
package sync_fifo_pkg;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_VALID = 1'b1
   } out_state_e;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_FIFO_DEPTH = 16;
   localparam int DEF_AE_THRESH  = 4;
   // almost_full default sits this many words below capacity
   localparam int DEF_AF_MARGIN  = 4;

   // level must hold 0..depth inclusive, hence one extra bit over the pointer
   function automatic int lvl_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft_if.sv
// Bundles the FIFO write/read/status/error signals between a producer-consumer and the FIFO.
// Latency: none, wires only.
// Backpressure: full/empty gate wr_en/rd_en inside the FIFO; the master should watch them.
interface sync_fifo_fwft_if
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int LVL_W      = lvl_width(DEF_FIFO_DEPTH)
);
   logic                  flush;
   logic                  wr_en;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_valid;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [LVL_W-1:0]      level;
   logic                  overflow;
   logic                  underflow;
   logic                  err_clr;

   modport master (
      output flush, wr_en, wr_data, rd_en, err_clr,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
             level, overflow, underflow
   );

   modport slave (
      input  flush, wr_en, wr_data, rd_en, err_clr,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty,
             level, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_mem.sv
// DATA_WIDTH x FIFO_DEPTH storage array, registered write port, combinational read port.
// Latency: write lands at the clock edge; read data follows rd_addr combinationally.
// No backpressure and no reset; the caller owns pointer and occupancy control.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
   localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [PTR_W-1:0]      wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [PTR_W-1:0]      rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

   // storage write; contents are intentionally left unreset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Synchronous FIFO with level, almost thresholds, flush and optional FWFT output stage.
// Latency: standard read data one edge after rd_en; FWFT head visible one edge after it is written.
// Backpressure: writes while full and reads while empty are dropped; SYNC_FIFO_ERR_FLAGS_EN adds sticky flags.
module sync_fifo_fwft
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int AF_THRESH  = FIFO_DEPTH - DEF_AF_MARGIN,
   parameter int AE_THRESH  = DEF_AE_THRESH,
   parameter int FWFT       = 0
) (
   input logic              clk,
   input logic              rst_n,   // active-high asynchronous reset
   sync_fifo_fwft_if.slave  bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = lvl_width(FIFO_DEPTH);

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   out_state_e            state_q, state_d;

   logic [DATA_WIDTH-1:0] mem_rd_data;
   logic [LVL_W-1:0]      mem_cnt;
   logic                  full;
   logic                  empty;
   logic                  wr_acc;   // word enters storage
   logic                  rd_acc;   // word leaves the FIFO as seen by the consumer
   logic                  load;     // head word moves from storage into rd_data

   assign full  = (level_q == LVL_W'(FIFO_DEPTH));
   assign empty = (FWFT != 0) ? (state_q == OUT_EMPTY) : (level_q == '0);

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_acc),
      .wr_addr (wr_ptr_q),
      .wr_data (bus.wr_data),
      .rd_addr (rd_ptr_q),
      .rd_data (mem_rd_data)
   );

   // next-state: pointers, level, output register and FWFT output FSM; flush overrides all
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      state_d    = state_q;
      rd_acc     = 1'b0;
      load       = 1'b0;

      // level includes the output register when it holds a word
      mem_cnt = level_q - {{(LVL_W-1){1'b0}}, (state_q == OUT_VALID)};
      wr_acc  = bus.wr_en && !full && !bus.flush;

      if (FWFT != 0) begin
         rd_acc = bus.rd_en && (state_q == OUT_VALID) && !bus.flush;
         load   = !bus.flush && (mem_cnt != '0) &&
                  ((state_q == OUT_EMPTY) || rd_acc);
         if (load) begin
            state_d = OUT_VALID;
         end else if (rd_acc) begin
            state_d = OUT_EMPTY;
         end
         rd_valid_d = (state_d == OUT_VALID);
      end else begin
         rd_acc     = bus.rd_en && (level_q != '0) && !bus.flush;
         load       = rd_acc;
         state_d    = OUT_EMPTY;
         rd_valid_d = rd_acc;
      end

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (load) begin
         rd_ptr_d  = rd_ptr_q + PTR_W'(1);
         rd_data_d = mem_rd_data;
      end

      case ({wr_acc, rd_acc})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      // rd_data is deliberately left holding across a flush
      if (bus.flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         state_d    = OUT_EMPTY;
         rd_valid_d = 1'b0;
      end
   end

   // state register for pointers, level, output stage and FSM
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         state_q    <= OUT_EMPTY;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         state_q    <= state_d;
      end
   end

   assign bus.rd_data      = rd_data_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.level        = level_q;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (level_q >= LVL_W'(AF_THRESH));
   assign bus.almost_empty = (level_q <= LVL_W'(AE_THRESH));

`ifdef SYNC_FIFO_ERR_FLAGS_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // sticky error flags; a clear wins over a new set in the same cycle
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (bus.err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (bus.wr_en && full) begin
            overflow_d = 1'b1;
         end
         if (bus.rd_en && empty) begin
            underflow_d = 1'b1;
         end
      end
   end

   // error flag registers
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = bus.err_clr;
   assign bus.overflow   = 1'b0;
   assign bus.underflow  = 1'b0;
`endif

endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Parametrised synchronous FIFO for the QSPI controller's AHB↔QSPI data paths (TX and RX buffering).
- Adds fill level, programmable almost-full/almost-empty thresholds, synchronous flush and an optional first-word-fall-through (FWFT) read mode.
- Error-flag logic can be compiled in or out.
- Sits between the AHB slave interface and the QSPI shift engine; one instance per direction.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits
- FIFO_DEPTH, 16, capacity in words; power of two, ≥ 2
- AF_THRESH, FIFO_DEPTH-4, almost_full asserts when level ≥ AF_THRESH
- AE_THRESH, 4, almost_empty asserts when level ≤ AE_THRESH
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-high reset (name kept for codebase consistency; asserted = 1)
- flush  in  1  synchronous clear of contents
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- rd_en  in  1  read request (standard) / pop acknowledge (FWFT)
- rd_data  out  DATA_WIDTH  read word
- rd_valid  out  1  standard: one-cycle pulse, rd_data updated this cycle; FWFT: rd_data holds a valid head word
- full, empty, almost_full, almost_empty  out  1 each  status
- level  out  $clog2(FIFO_DEPTH)+1  words held
- overflow, underflow  out  1 each  sticky error flags (SYNC_FIFO_ERR_FLAGS_EN only)
- err_clr  in  1  clears sticky flags (SYNC_FIFO_ERR_FLAGS_EN only)

## Operation
- Write accepted iff wr_en && !full.
  - A simultaneous read does not free space in the same cycle.
  - A write while full is dropped.
- Read accepted iff rd_en && !empty. A read while empty is ignored, and rd_data holds.
- Pointers wrap modulo FIFO_DEPTH.
- level:
  - +1 on a write only, −1 on a read only, unchanged when both are accepted.
  - Never exceeds FIFO_DEPTH and never underflows.
- Status decodes, combinational from registered level / output state:
  - full = (level == FIFO_DEPTH)
  - almost_full = (level ≥ AF_THRESH)
  - almost_empty = (level ≤ AE_THRESH)
- Standard mode: empty = (level == 0). An accepted read loads rd_data from the head at the next edge and pulses rd_valid for one cycle.
- FWFT mode: output register with a two-state FSM.
  - OUT_EMPTY → OUT_VALID when memory is non-empty: the head is loaded into rd_data and the read pointer advances.
  - OUT_VALID with rd_en:
    - memory non-empty: reload next word, stay in OUT_VALID.
    - memory empty: go to OUT_EMPTY.
  - empty = (state == OUT_EMPTY); rd_valid = !empty.
  - level counts memory words plus the output register; total capacity is FIFO_DEPTH.
- flush:
  - Next edge: level = 0, pointers = 0, FSM → OUT_EMPTY, rd_valid = 0.
  - Overrides wr_en and rd_en in the same cycle.
  - rd_data holds its value; sticky flags are unaffected.
- Reset values:
  - rd_data 0, rd_valid 0, level 0
  - empty 1, full 0, almost_full 0, almost_empty 1
  - overflow 0, underflow 0, FSM OUT_EMPTY
  - Memory contents are not reset.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); in-flight words are lost.

## Timing
- Standard read latency: rd_en sampled at edge N → rd_data/rd_valid valid after edge N.
- Write-to-readable:
  - Standard: word written at edge N can be read from cycle N+1.
  - FWFT: word written to an empty FIFO at edge N appears on rd_data with empty=0 after edge N+1.
- Flags and level update on the same edge as the accepted operation.

## Configuration
- SYNC_FIFO_ERR_FLAGS_EN defined:
  - overflow sets on wr_en && full; underflow sets on rd_en && empty.
  - Both are sticky until err_clr or reset; err_clr has priority over a new set in the same cycle.
- Not defined: overflow/underflow tied to 0, err_clr ignored, no flag registers.

## Structure
- Package sync_fifo_pkg:
  - out_state_e enum (OUT_EMPTY, OUT_VALID)
  - function for level width
  - default threshold constants
- One sub-module: sync_fifo_mem
  - DATA_WIDTH × FIFO_DEPTH storage
  - registered write port, combinational read address port
  - no reset
- sync_fifo_fwft contains pointers, level, status decode, FWFT FSM and error flags.

## Test plan
- Reset, then 16 writes of 0x0..0xF (DEPTH 16, AF 12, AE 4):
  - almost_empty drops at level 5; almost_full rises at level 12; full at 16.
  - 17th write dropped; overflow=1 (macro on).
- Standard mode, read 16 words → rd_data 0x0..0xF in order, each one cycle after rd_en with rd_valid pulse; then empty=1; extra rd_en → underflow=1, rd_data stays 0xF.
- Simultaneous wr_en/rd_en at level 8 for 20 cycles → level stays 8; pointers wrap; data order preserved.
- FWFT=1: write 0xA5 into empty FIFO → rd_data=0xA5, empty=0 two edges after write; rd_en → empty=1, level=0.
- flush at level 10 with wr_en=1 in the same cycle → level=0, empty=1 next edge; subsequent write of 0x3C read back first.
- Assert rst_n mid-burst at level 7 → all outputs at reset values immediately; err_clr clears sticky flags; macro off → flags stay 0 under overflow.
